// File: rtl/ife_window_scheduler_if.sv
// Host, image ROM, filter datapath and output memory signals
// seen by the 3x3 window scheduler.
interface ife_window_scheduler_if #(
   parameter int AW = 14,
   parameter int DW = 8
);
   logic          ready;
   logic          busy;
   logic [AW-1:0] iaddr;
   logic [DW-1:0] idata;
   logic          smp_valid;
   logic [DW-1:0] smp_data;
   logic          smp_first;
   logic          smp_last;
   logic          res_valid;
   logic [DW-1:0] res_data;
   logic          wen;
   logic [AW-1:0] addr;
   logic [DW-1:0] data_wr;
   logic          done;

   modport master (
      input  ready, idata, res_valid, res_data,
      output busy, iaddr, smp_valid, smp_data, smp_first,
             smp_last, wen, addr, data_wr, done
   );

   modport slave (
      output ready, idata, res_valid, res_data,
      input  busy, iaddr, smp_valid, smp_data, smp_first,
             smp_last, wen, addr, data_wr, done
   );
endinterface

// File: rtl/ife_window_scheduler.sv
// Raster walker for the 3x3 filter: issues zero-padded window
// reads, streams samples, waits for the result and writes it.
module ife_window_scheduler #(
   parameter int IMG_W = 128,
   parameter int IMG_H = 128,
   parameter int AW    = 14,
   parameter int DW    = 8
) (
   input logic                    clk,
   input logic                    reset,
   ife_window_scheduler_if.master bus
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_WAIT_RES,
      S_WRITE,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [3:0]    k_q, k_d;
   logic          sv_q, sv_d;
   logic          sf_q, sf_d;
   logic          sl_q, sl_d;
   logic          oob_q, oob_d;
   logic          wen_q, wen_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;

   int            cx, cy, nx, ny;
   logic          oob;
   logic [AW-1:0] ctr_addr;
   logic [AW-1:0] win_addr;

   // Signed neighbour coordinates, so x=0,dx=-1 never wraps a row.
   always_comb begin
      cx       = int'(x_q);
      cy       = int'(y_q);
      nx       = cx + int'(k_q) % 3 - 1;
      ny       = cy + int'(k_q) / 3 - 1;
      oob      = (nx < 0) || (nx >= IMG_W) ||
                 (ny < 0) || (ny >= IMG_H);
      ctr_addr = AW'(cy * IMG_W + cx);
      win_addr = oob ? ctr_addr : AW'(ny * IMG_W + nx);
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      k_d     = k_q;
      sv_d    = 1'b0;
      sf_d    = 1'b0;
      sl_d    = 1'b0;
      oob_d   = 1'b0;
      wen_d   = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.ready) begin
               x_d     = '0;
               y_d     = '0;
               k_d     = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            sv_d  = 1'b1;
            sf_d  = (k_q == 4'd0);
            sl_d  = (k_q == 4'd8);
            oob_d = oob;
            if (k_q == 4'd8) begin
               k_d     = '0;
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         S_DRAIN: state_d = S_WAIT_RES;
         S_WAIT_RES: begin
            if (bus.res_valid) begin
               wen_d   = 1'b1;
               addr_d  = ctr_addr;
               data_d  = bus.res_data;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (x_q == X_MAX && y_q == Y_MAX) begin
               state_d = S_DONE;
            end else begin
               if (x_q == X_MAX) begin
                  x_d = '0;
                  y_d = y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
               state_d = S_FETCH;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         k_q     <= '0;
         sv_q    <= 1'b0;
         sf_q    <= 1'b0;
         sl_q    <= 1'b0;
         oob_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         k_q     <= k_d;
         sv_q    <= sv_d;
         sf_q    <= sf_d;
         sl_q    <= sl_d;
         oob_q   <= oob_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign bus.busy      = (state_q == S_FETCH) ||
                          (state_q == S_DRAIN) ||
                          (state_q == S_WAIT_RES) ||
                          (state_q == S_WRITE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.iaddr     = (state_q == S_FETCH) ? win_addr : '0;
   assign bus.smp_valid = sv_q;
   assign bus.smp_first = sf_q;
   assign bus.smp_last  = sl_q;
   assign bus.smp_data  = (sv_q && !oob_q) ? bus.idata : '0;
   assign bus.wen       = wen_q;
   assign bus.addr      = addr_q;
   assign bus.data_wr   = data_q;
endmodule
